// File: rtl/barrel_shift_arbiter.sv
// -----------------------------------------------------------------------------
// barrel_shift_arbiter
//
// Shares one 8-bit rotate-right barrel shifter among up to four requesters.
// A round-robin arbiter picks one valid requester per cycle. The granted
// operand is rotated by that requester's amount. The result is registered
// together with the winner's index and offered on a single valid/ready port.
//
// Parameters
//   NREQ        number of requesters (2..4)
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         synchronous active-high reset
//   req_valid   [NREQ]    per-requester request valid
//   req_data    [8*NREQ]  packed operands, requester i at [8i+7:8i]
//   req_shift   [3*NREQ]  packed rotate amounts, requester i at [3i+2:3i]
//   req_ready   [NREQ]    one-hot (or zero) accept back to the requesters
//   rsp_valid   registered result valid
//   rsp_data    rotated operand
//   rsp_id      index of the requester that produced rsp_data
//   rsp_ready   downstream accept
// -----------------------------------------------------------------------------
module barrel_shift_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_data,
    input  logic [3*NREQ-1:0]   req_shift,
    output logic [NREQ-1:0]     req_ready,
    output logic                rsp_valid,
    output logic [7:0]          rsp_data,
    output logic [1:0]          rsp_id,
    input  logic                rsp_ready
);

    localparam int MAXREQ = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  ptr_q,   ptr_d;
    logic [7:0]  data_q,  data_d;
    logic [1:0]  id_q,    id_d;

    // Requester inputs widened to the maximum requester count. Slots beyond
    // NREQ are tied off so they can never be granted.
    logic [MAXREQ-1:0] valid_pad;
    logic [7:0]        data_pad  [MAXREQ];
    logic [2:0]        shift_pad [MAXREQ];

    generate
        for (genvar gi = 0; gi < MAXREQ; gi++) begin : g_pad
            if (gi < NREQ) begin : g_used
                assign valid_pad[gi] = req_valid[gi];
                assign data_pad[gi]  = req_data[8*gi +: 8];
                assign shift_pad[gi] = req_shift[3*gi +: 3];
            end else begin : g_tied
                assign valid_pad[gi] = 1'b0;
                assign data_pad[gi]  = 8'h00;
                assign shift_pad[gi] = 3'd0;
            end
        end
    endgenerate

    // Candidate requester index for each search offset from the pointer,
    // wrapping modulo NREQ.
    logic [1:0] cand_idx [MAXREQ];

    generate
        for (genvar gi = 0; gi < MAXREQ; gi++) begin : g_cand
            if (gi < NREQ) begin : g_live
                logic [2:0] sum;
                assign sum = {1'b0, ptr_q} + 3'(gi);
                assign cand_idx[gi] = (sum >= 3'(NREQ)) ? 2'(sum - 3'(NREQ))
                                                        : sum[1:0];
            end else begin : g_dead
                assign cand_idx[gi] = 2'd0;
            end
        end
    endgenerate

    // Pick the first valid candidate. Scanning from the far end means the
    // nearest offset to the pointer is the last to be written, so it wins.
    logic       grant_found;
    logic [1:0] grant_idx;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 2'd0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (valid_pad[cand_idx[k]]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx[k];
            end
        end
    end

    // The output register may take a new value when it is empty or being
    // drained this cycle. Reset suppresses every grant.
    logic load_en;
    logic accept;

    assign load_en = (state_q == EMPTY) | rsp_ready;
    assign accept  = load_en & grant_found & ~rst;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = accept & (grant_idx == 2'(gi));
        end
    endgenerate

    // Shared shifter: route the winner's operand and amount in, then rotate
    // right by indexing into the operand concatenated with itself.
    logic [7:0]  sel_data;
    logic [2:0]  sel_shift;
    logic [15:0] sel_dbl;
    logic [7:0]  rot_data;

    assign sel_data  = data_pad[grant_idx];
    assign sel_shift = shift_pad[grant_idx];
    assign sel_dbl   = {sel_data, sel_data};

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rot
            assign rot_data[gi] = sel_dbl[4'(gi) + {1'b0, sel_shift}];
        end
    endgenerate

    // The pointer moves to the slot just after the winner.
    logic [1:0] ptr_after_grant;
    assign ptr_after_grant = (grant_idx == 2'(NREQ - 1)) ? 2'd0 : grant_idx + 2'd1;

    // Output stage FSM: next state and register loads.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        id_d    = id_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = FULL;
                    ptr_d   = ptr_after_grant;
                    data_d  = rot_data;
                    id_d    = grant_idx;
                end
            end
            FULL: begin
                if (accept) begin
                    // Drain and reload at the same edge, no bubble.
                    ptr_d  = ptr_after_grant;
                    data_d = rot_data;
                    id_d   = grant_idx;
                end else if (rsp_ready) begin
                    // Drained with nothing to replace it; data and id hold.
                    state_d = EMPTY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            ptr_q   <= 2'd0;
            data_q  <= 8'h00;
            id_q    <= 2'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            id_q    <= id_d;
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_data  = data_q;
    assign rsp_id    = id_q;

endmodule
